data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameter RAM_WORDS, 256, depth of data RAM in 32-bit words (power of two, max 256).
REQ-002 Parameter SW_WIDTH, 10, width of switch input bank.
REQ-003 Parameter LED_WIDTH, 10, width of LED output register.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; integrator inverts the core's active-high reset.
REQ-006 MemWrite  input  1  core write strobe, valid for the current cycle.
REQ-007 ALUResult  input  32  core byte address.
REQ-008 WriteData  input  32  core store data.
REQ-009 ReadData  output  32  load data returned to core.
REQ-010 sw  input  SW_WIDTH  asynchronous external switches.
REQ-011 led  output  LED_WIDTH  LED register contents.
REQ-012 irq  output  1  timer interrupt request, level.

Function
REQ-013 Address decode SHALL use ALUResult[31:2]; ALUResult[1:0] ignored (word access only).
REQ-014 Map: 0x000-0x3FF RAM (index ALUResult[9:2] mod RAM_WORDS); 0x400 LED RW; 0x404 SW RO; 0x408 CYCLE RO; 0x40C TCMP RW; 0x410 TCTRL RW; 0x414 TCOUNT RO; all else unmapped.
REQ-015 ReadData SHALL be combinational from current address and current registered state (zero-latency read, single-cycle core).
REQ-016 Writes SHALL take effect at the rising edge where MemWrite=1; RO and unmapped writes ignored; unmapped reads return 0.
REQ-017 LED reads return zero-extended led; writes load WriteData[LED_WIDTH-1:0].
REQ-018 SW reads return zero-extended sw after a 2-flop synchronizer (2-cycle input latency).
REQ-019 CYCLE SHALL increment by 1 every cycle, wrap 0xFFFFFFFF->0.
REQ-020 TCTRL bits: [0] enable, [1] flag (sticky, write-1-to-clear), [2] irq_en; bits [31:3] read 0.
REQ-021 Writes to TCTRL load bits 0 and 2 from WriteData; WriteData[1]=1 clears flag, 0 leaves it.
REQ-022 Timer: while enable=1, TCOUNT increments each cycle; when TCOUNT==TCMP, next edge sets flag and loads TCOUNT=0.
REQ-023 While enable=0, TCOUNT holds; writing enable 1->0->1 does not clear TCOUNT.
REQ-024 Match uses pre-edge TCMP; a same-cycle TCMP write affects the next comparison only.
REQ-025 Simultaneous match and flag-clear write: set wins, flag=1.
REQ-026 TCMP=0 with enable=1: flag sets every cycle, TCOUNT stays 0.
REQ-027 irq SHALL equal flag AND irq_en (combinational from registers, no extra delay).
REQ-028 RAM reads of unwritten locations return undefined data; bench does not check them.

Reset
REQ-029 While reset=0: led=0, CYCLE=0, TCMP=0, TCTRL=0, TCOUNT=0, synchronizer flops=0, irq=0.
REQ-030 RAM contents SHALL NOT be reset and SHALL be retained through a reset pulse.
REQ-031 Reset asserted mid-operation clears the registers immediately, independent of clk; a write in that cycle is lost.
REQ-032 First CYCLE increment occurs at the first rising edge after reset deasserts.

Structure
REQ-033 Shared package SHALL hold the address map constants (region bases, register offsets) and TCTRL bit indices.
REQ-034 Timer (TCMP, TCTRL, TCOUNT, match, irq) SHALL be sub-module io_timer; decode, RAM, LED, SW, CYCLE stay in top.
REQ-035 RAM SHALL be inferrable as distributed RAM (async read, sync write).

Verification
REQ-036 Write 0xDEADBEEF to 0x010, then read 0x010 and 0x013 -> both 0xDEADBEEF; read 0x400 after reset -> 0.
REQ-037 Drive sw=0x2A5 -> read 0x404 returns 0x2A5 from the 3rd edge on, 0 before.
REQ-038 Reset release, read 0x408 after 10 edges -> 10; force 0xFFFFFFFF -> wraps to 0.
REQ-039 TCMP=3, TCTRL=0x5 -> flag and irq=1 four cycles after enable, TCOUNT=0; write TCTRL=0x7 in match cycle -> flag stays 1; later write 0x7 -> irq=0.
REQ-040 Write 0x12345678 to 0x800 (unmapped) and 0x404 -> reads 0 and switch value; RAM word 0 unchanged.
REQ-041 Pulse reset mid-timer-count -> TCOUNT, TCTRL, led, irq=0 immediately; RAM word at 0x010 still 0xDEADBEEF.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// ============================================================================
// data_bus_responder_pkg : address map, TCTRL bit positions and decode helper
// Rev 1.0
// ============================================================================
`default_nettype none

package data_bus_responder_pkg;

    localparam logic [31:0] RAM_SPAN    = 32'h0000_0400;
    localparam logic [31:0] IO_BASE     = 32'h0000_0400;

    localparam logic [31:0] OFF_LED     = 32'h00;
    localparam logic [31:0] OFF_SW      = 32'h04;
    localparam logic [31:0] OFF_CYCLE   = 32'h08;
    localparam logic [31:0] OFF_TCMP    = 32'h0C;
    localparam logic [31:0] OFF_TCTRL   = 32'h10;
    localparam logic [31:0] OFF_TCOUNT  = 32'h14;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_FLAG   = 1;
    localparam int TCTRL_IRQEN  = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CYCLE,
        SEL_TCMP,
        SEL_TCTRL,
        SEL_TCOUNT
    } sel_e;

    // Takes the word address only, so byte-lane bits can never influence the map.
    function automatic sel_e decode_addr(input logic [29:0] word);
        logic [31:0] a;
        a = {word, 2'b00};
        if (a < RAM_SPAN)                  return SEL_RAM;
        else if (a == IO_BASE + OFF_LED)    return SEL_LED;
        else if (a == IO_BASE + OFF_SW)     return SEL_SW;
        else if (a == IO_BASE + OFF_CYCLE)  return SEL_CYCLE;
        else if (a == IO_BASE + OFF_TCMP)   return SEL_TCMP;
        else if (a == IO_BASE + OFF_TCTRL)  return SEL_TCTRL;
        else if (a == IO_BASE + OFF_TCOUNT) return SEL_TCOUNT;
        else                                return SEL_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_bus_responder_io_timer.sv
// ============================================================================
// io_timer : compare-match timer with sticky W1C flag and level interrupt
// Rev 1.0
// ============================================================================
`default_nettype none

module io_timer
    import data_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_tcmp,
    input  logic        we_tctrl,
    input  logic [31:0] wdata,
    output logic [31:0] tcmp,
    output logic [31:0] tctrl,
    output logic [31:0] tcount,
    output logic        irq
);

    logic enable;
    logic flag;
    logic irq_en;
    logic match;

    // Compare against the pre-edge TCMP so a same-cycle TCMP write only affects later matches.
    assign match = enable && (tcount == tcmp);
    assign irq   = flag && irq_en;

    always_comb begin
        tctrl              = '0;
        tctrl[TCTRL_EN]    = enable;
        tctrl[TCTRL_FLAG]  = flag;
        tctrl[TCTRL_IRQEN] = irq_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcmp   <= '0;
            enable <= 1'b0;
            irq_en <= 1'b0;
            flag   <= 1'b0;
            tcount <= '0;
        end else begin
            if (we_tcmp) begin
                tcmp <= wdata;
            end
            if (we_tctrl) begin
                enable <= wdata[TCTRL_EN];
                irq_en <= wdata[TCTRL_IRQEN];
            end
            // A match outranks a simultaneous write-1-to-clear.
            if (match) begin
                flag <= 1'b1;
            end else if (we_tctrl && wdata[TCTRL_FLAG]) begin
                flag <= 1'b0;
            end
            if (match) begin
                tcount <= '0;
            end else if (enable) begin
                tcount <= tcount + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_bus_responder.sv
// ============================================================================
// data_bus_responder : memory-mapped RAM, LED, switches, cycle counter, timer
// Rev 1.0
// ============================================================================
`default_nettype none

module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int SW_WIDTH  = 10,
    parameter int LED_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemWrite,
    input  logic [31:0]          ALUResult,
    input  logic [31:0]          WriteData,
    output logic [31:0]          ReadData,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] led,
    output logic                 irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    sel_e              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [31:0]       cycle_count;
    logic [31:0]       tcmp;
    logic [31:0]       tctrl;
    logic [31:0]       tcount;
    logic              unused_byte_lane;

    assign sel              = decode_addr(ALUResult[31:2]);
    assign ram_idx          = ALUResult[RAM_AW+1:2];
    assign unused_byte_lane = ^ALUResult[1:0];

    // No reset here so the array maps onto distributed RAM and survives reset pulses.
    always_ff @(posedge clk) begin
        if (MemWrite && sel == SEL_RAM) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led         <= '0;
            sw_meta     <= '0;
            sw_sync     <= '0;
            cycle_count <= '0;
        end else begin
            if (MemWrite && sel == SEL_LED) begin
                led <= WriteData[LED_WIDTH-1:0];
            end
            sw_meta     <= sw;
            sw_sync     <= sw_meta;
            cycle_count <= cycle_count + 32'd1;
        end
    end

    io_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .we_tcmp  (MemWrite && sel == SEL_TCMP),
        .we_tctrl (MemWrite && sel == SEL_TCTRL),
        .wdata    (WriteData),
        .tcmp     (tcmp),
        .tctrl    (tctrl),
        .tcount   (tcount),
        .irq      (irq)
    );

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:    ReadData = ram[ram_idx];
            SEL_LED:    ReadData = 32'(led);
            SEL_SW:     ReadData = 32'(sw_sync);
            SEL_CYCLE:  ReadData = cycle_count;
            SEL_TCMP:   ReadData = tcmp;
            SEL_TCTRL:  ReadData = tctrl;
            SEL_TCOUNT: ReadData = tcount;
            default:    ReadData = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: stimulus queues expectations, a
// negedge monitor pops them and compares against ReadData, irq or led.
`default_nettype none

module tb_data_bus_responder;

    localparam int K_READ = 0;
    localparam int K_IRQ  = 1;
    localparam int K_LED  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [9:0]  sw;
    logic [9:0]  led;
    logic        irq;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        chk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    data_bus_responder #(
        .RAM_WORDS (256),
        .SW_WIDTH  (10),
        .LED_WIDTH (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .sw        (sw),
        .led       (led),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL scoreboard_empty actual=no_entry required=entry");
            end else begin
                int          k;
                logic [31:0] e;
                logic [31:0] act;
                string       n;
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                case (k)
                    K_IRQ:   act = {31'b0, irq};
                    K_LED:   act = {22'b0, led};
                    default: act = ReadData;
                endcase
                if (act !== e) begin
                    failures = failures + 1;
                    $display("FAIL %s actual=0x%08h required=0x%08h", n, act, e);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic push_exp(input int k, input logic [31:0] e, input string n);
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        MemWrite  = 1'b0;
        ALUResult = a;
        push_exp(K_READ, e, n);
        chk = 1'b1;
        @(posedge clk); #1;
        chk = 1'b0;
    endtask

    task automatic probe(input int k, input logic [31:0] e, input string n);
        MemWrite  = 1'b0;
        ALUResult = 32'h0000_0800;
        push_exp(k, e, n);
        chk = 1'b1;
        @(posedge clk); #1;
        chk = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        @(posedge clk); #1;
        MemWrite  = 1'b0;
    endtask

    task automatic idle(input int n);
        MemWrite  = 1'b0;
        ALUResult = 32'h0000_0800;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = 32'h0000_0800;
        WriteData = 32'h0;
        sw        = 10'h0;
        @(posedge clk); #1;

        // Register state held in reset
        rd(32'h400, 32'h0, "led_in_reset");
        rd(32'h408, 32'h0, "cycle_in_reset");
        rd(32'h40C, 32'h0, "tcmp_in_reset");
        rd(32'h410, 32'h0, "tctrl_in_reset");
        rd(32'h414, 32'h0, "tcount_in_reset");
        probe(K_IRQ, 32'h0, "irq_in_reset");

        // Cycle counter starts at the first edge after release
        reset = 1'b1;
        idle(10);
        rd(32'h408, 32'd10, "cycle_after_10_edges");

        // RAM word access, byte-lane bits ignored
        wr(32'h010, 32'hDEAD_BEEF);
        rd(32'h010, 32'hDEAD_BEEF, "ram_read_010");
        rd(32'h013, 32'hDEAD_BEEF, "ram_read_013");
        rd(32'h400, 32'h0, "led_after_reset");

        // LED truncated to 10 bits
        wr(32'h400, 32'hFFFF_FFFF);
        rd(32'h400, 32'h0000_03FF, "led_readback");
        probe(K_LED, 32'h0000_03FF, "led_port");

        // Switch synchronizer latency
        sw = 10'h2A5;
        rd(32'h404, 32'h0, "sw_before_edge");
        rd(32'h404, 32'h0, "sw_after_1_edge");
        idle(1);
        rd(32'h404, 32'h0000_02A5, "sw_after_3_edges");

        // Unmapped and read-only writes ignored; 0x800 must not alias RAM word 0
        wr(32'h000, 32'h0BAD_F00D);
        wr(32'h800, 32'h1234_5678);
        wr(32'h404, 32'h1234_5678);
        rd(32'h800, 32'h0, "unmapped_read");
        rd(32'h404, 32'h0000_02A5, "sw_after_write");
        rd(32'h000, 32'h0BAD_F00D, "ram0_unchanged");

        // Cycle counter wrap
        force dut.cycle_count = 32'hFFFF_FFFF;
        MemWrite  = 1'b0;
        ALUResult = 32'h408;
        push_exp(K_READ, 32'hFFFF_FFFF, "cycle_forced");
        chk = 1'b1;
        @(negedge clk); #1;
        release dut.cycle_count;
        @(posedge clk); #1;
        chk = 1'b0;
        rd(32'h408, 32'h0, "cycle_wrap");

        // Timer: TCMP=3, enable with irq_en; flag at the 4th edge after enable
        wr(32'h40C, 32'd3);
        rd(32'h40C, 32'd3, "tcmp_readback");
        wr(32'h410, 32'h5);
        rd(32'h414, 32'd0, "tcount_start");
        probe(K_IRQ, 32'h0, "irq_before_match");
        rd(32'h414, 32'd2, "tcount_run");
        wr(32'h410, 32'h7);
        rd(32'h414, 32'd0, "tcount_reload");
        probe(K_IRQ, 32'h1, "irq_set_wins_over_clear");
        wr(32'h410, 32'h7);
        probe(K_IRQ, 32'h0, "irq_after_w1c");
        rd(32'h410, 32'h7, "tctrl_flag_periodic");

        // Asynchronous reset mid-count: visible before any clock edge
        reset = 1'b0;
        rd(32'h414, 32'h0, "tcount_async_reset");
        probe(K_IRQ, 32'h0, "irq_async_reset");
        probe(K_LED, 32'h0, "led_async_reset");
        rd(32'h410, 32'h0, "tctrl_async_reset");
        wr(32'h400, 32'h155);
        reset = 1'b1;
        rd(32'h400, 32'h0, "led_write_lost_in_reset");
        rd(32'h010, 32'hDEAD_BEEF, "ram_retained");

        // TCMP=0: flag every cycle, count pinned at 0, set beats clear
        wr(32'h410, 32'h1);
        rd(32'h414, 32'h0, "tcount_tcmp0");
        rd(32'h410, 32'h3, "tctrl_tcmp0_flag");
        wr(32'h410, 32'h2);
        rd(32'h410, 32'h2, "tctrl_disable_set_wins");
        wr(32'h410, 32'h2);
        rd(32'h410, 32'h0, "tctrl_flag_cleared");

        idle(2);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
